uart_tx_fifo: RTL and testbench

Transmit-side buffer placed directly upstream of the no-parity and even-parity UART cores. It accepts words from the core-side bus through a valid/ready handshake and stores them in a power-of-two FIFO. It hands them one at a time to the UART transmitter's `write` / `T_W` / `T_locked` interface, holding each request until the transmitter acknowledges it, so the producer never has to track the UART's reduced bit clock.

---
 rtl/uart_tx_fifo.sv | 123 ++++++++++++
 tb/tb_uart_tx_fifo.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Transmit FIFO feeding a UART core's write/T_W/T_locked request interface.
// Optional sticky overflow flag is enabled by defining UART_TX_FIFO_OVERFLOW_EN.
module uart_tx_fifo #(
    parameter int word_width = 8,
    parameter int depth      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [word_width-1:0] in_data,
    output logic                  in_ready,
    output logic                  tx_write,
    output logic [word_width-1:0] tx_word,
    input  logic                  tx_locked,
    output logic                  empty,
    output logic                  overflow,
    input  logic                  overflow_clr
);

    localparam int AW = $clog2(depth);
    localparam int PW = AW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                state_q;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [word_width-1:0] mem_q [depth];
    logic [word_width-1:0] tx_word_q;
    logic                  tx_write_q;
    logic                  full;
    logic                  push;
    logic                  pop;

    // Full/empty come only from registered pointers, so in_ready never depends on in_valid.
    assign full     = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign in_ready = ~full;

    assign push     = in_valid & ~full;
    assign pop      = (state_q == SEND) & tx_locked;
    assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
    assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= in_data;
        end
    end

    // A word is popped only once the UART reports busy, so a request is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            tx_write_q <= 1'b0;
            tx_word_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!empty) begin
                        tx_word_q  <= mem_q[rd_ptr_q[AW-1:0]];
                        tx_write_q <= 1'b1;
                        state_q    <= SEND;
                    end
                end
                SEND: begin
                    if (tx_locked) begin
                        tx_write_q <= 1'b0;
                        state_q    <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!tx_locked) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    tx_write_q <= 1'b0;
                end
            endcase
        end
    end

    assign tx_write = tx_write_q;
    assign tx_word  = tx_word_q;

`ifdef UART_TX_FIFO_OVERFLOW_EN
    logic overflow_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
        end else if (overflow_clr) begin
            overflow_q <= 1'b0;
        end else if (in_valid && full) begin
            overflow_q <= 1'b1;
        end
    end

    assign overflow = overflow_q;
`else
    logic unused_overflow_clr;

    assign unused_overflow_clr = overflow_clr;
    assign overflow            = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a simple UART busy model on tx_locked.
// Overflow expectations follow UART_TX_FIFO_OVERFLOW_EN.
module tb_uart_tx_fifo;

    logic       clk          = 1'b0;
    logic       rst_n        = 1'b0;
    logic       in_valid     = 1'b0;
    logic [7:0] in_data      = 8'h00;
    logic       overflow_clr = 1'b0;
    logic       in_ready;
    logic       tx_write;
    logic [7:0] tx_word;
    logic       tx_locked;
    logic       empty;
    logic       overflow;

    logic       auto_mode    = 1'b0;
    logic       man_locked   = 1'b0;
    logic       model_locked = 1'b0;
    logic       prev_write   = 1'b0;
    int         busy_len     = 40;
    int         busy_cnt     = 0;
    int         ep_cnt       = 0;
    logic [7:0] cap [$];

    int errors = 0;
    int checks = 0;

`ifdef UART_TX_FIFO_OVERFLOW_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    assign tx_locked = auto_mode ? model_locked : man_locked;

    uart_tx_fifo #(.word_width(8), .depth(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .tx_write     (tx_write),
        .tx_word      (tx_word),
        .tx_locked    (tx_locked),
        .empty        (empty),
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
    );

    always #5 clk = ~clk;

    // UART model: accepts a pending request, then stays busy for busy_len cycles.
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_cnt     = 0;
            model_locked = 1'b0;
            prev_write   = 1'b0;
        end else begin
            if (tx_write && !prev_write) ep_cnt++;
            prev_write = tx_write;
            if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) model_locked = 1'b0;
            end else if (auto_mode && tx_write && !model_locked) begin
                cap.push_back(tx_word);
                model_locked = 1'b1;
                busy_cnt     = busy_len;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        int mism;

        // Reset state
        step(2);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_empty",    32'(empty),    32'd1);
        check("rst_tx_write", 32'(tx_write), 32'd0);
        check("rst_tx_word",  32'(tx_word),  32'h00);
        check("rst_overflow", 32'(overflow), 32'd0);
        rst_n = 1'b1;
        step(1);

        // Single word with a long-held request
        in_valid = 1'b1; in_data = 8'hA5;
        step(1);
        in_valid = 1'b0;
        check("a5_not_yet",   32'(tx_write), 32'd0);
        check("a5_nonempty",  32'(empty),    32'd0);
        step(1);
        check("a5_write",     32'(tx_write), 32'd1);
        check("a5_word",      32'(tx_word),  32'hA5);
        step(20);
        check("a5_held",      32'(tx_write), 32'd1);
        check("a5_held_word", 32'(tx_word),  32'hA5);
        man_locked = 1'b1;
        step(1);
        check("a5_dropped",   32'(tx_write), 32'd0);
        check("a5_popped",    32'(empty),    32'd1);
        check("a5_word_keep", 32'(tx_word),  32'hA5);
        man_locked = 1'b0;
        step(2);
        check("a5_idle",      32'(tx_write), 32'd0);

        // Asynchronous reset while a request is pending
        in_valid = 1'b1; in_data = 8'h3C;
        step(1);
        in_valid = 1'b0;
        step(1);
        check("ar_write_pre", 32'(tx_write), 32'd1);
        rst_n = 1'b0;
        #1;
        check("ar_write_drop", 32'(tx_write), 32'd0);
        check("ar_empty",      32'(empty),    32'd1);
        check("ar_word",       32'(tx_word),  32'h00);
        step(1);
        rst_n = 1'b1;
        step(1);

        // Fill with the UART stalled, then a refused 17th push
        ep_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1; in_data = 8'(i);
            step(1);
        end
        in_valid = 1'b0;
        check("full_ready",    32'(in_ready), 32'd0);
        check("full_sendword", 32'(tx_word),  32'h00);
        in_valid = 1'b1; in_data = 8'hFF;
        step(1);
        in_valid = 1'b0;
        check("ovf_ready",  32'(in_ready), 32'd0);
        check("ovf_set",    32'(overflow), 32'(OVF_EXP));
        step(3);
        check("ovf_sticky", 32'(overflow), 32'(OVF_EXP));
        overflow_clr = 1'b1;
        step(1);
        overflow_clr = 1'b0;
        check("ovf_clr",    32'(overflow), 32'd0);

        // Release the UART model, 40 busy cycles per word
        cap.delete();
        busy_len  = 40;
        auto_mode = 1'b1;
        for (int k = 0; k < 4000 && !(cap.size() == 16 && busy_cnt == 0); k++) step(1);
        step(5);
        check("drain_count", 32'(cap.size()), 32'd16);
        mism = 0;
        for (int i = 0; i < 16; i++) begin
            if (i >= cap.size() || cap[i] !== 8'(i)) mism++;
        end
        check("drain_order",    32'(mism),   32'd0);
        check("drain_episodes", 32'(ep_cnt), 32'd16);
        check("drain_empty",    32'(empty),  32'd1);

        // Continuous push and drain of 100 words through the wrapping pointers
        cap.delete();
        ep_cnt   = 0;
        busy_len = 3;
        for (int i = 0; i < 100; i++) begin
            in_valid = 1'b1; in_data = 8'(i);
            for (int k = 0; k < 200 && !in_ready; k++) step(1);
            step(1);
        end
        in_valid = 1'b0;
        for (int k = 0; k < 3000 && !(cap.size() == 100 && busy_cnt == 0); k++) step(1);
        step(5);
        check("stream_count", 32'(cap.size()), 32'd100);
        mism = 0;
        for (int i = 0; i < 100; i++) begin
            if (i >= cap.size() || cap[i] !== 8'(i)) mism++;
        end
        check("stream_order",    32'(mism),   32'd0);
        check("stream_episodes", 32'(ep_cnt), 32'd100);
        check("stream_empty",    32'(empty),  32'd1);
        auto_mode    = 1'b0;
        overflow_clr = 1'b1;
        step(1);
        overflow_clr = 1'b0;

        // Push coinciding with pop while one entry is stored
        in_valid = 1'b1; in_data = 8'h11;
        step(1);
        in_valid = 1'b0;
        step(1);
        check("pp_send_word", 32'(tx_word), 32'h11);
        man_locked = 1'b1;
        in_valid = 1'b1; in_data = 8'h22;
        step(1);
        in_valid = 1'b0;
        check("pp_occupied", 32'(empty),    32'd0);
        check("pp_ready",    32'(in_ready), 32'd1);
        check("pp_dropped",  32'(tx_write), 32'd0);
        man_locked = 1'b0;
        step(2);
        check("pp_next_write", 32'(tx_write), 32'd1);
        check("pp_next_word",  32'(tx_word),  32'h22);
        man_locked = 1'b1;
        step(1);
        check("pp_final_empty", 32'(empty), 32'd1);
        man_locked = 1'b0;
        step(2);
        check("final_overflow", 32'(overflow), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
